// File: rtl/decode_stage.sv
// RV32I decode stage: control decode, 32x32 register file, immediate extend, ID/EX register.
// Optional writeback-to-read bypass enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [31:0] regs_r [32];
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        reg_write_s, mem_write_s, jump_s, branch_s, alu_src_s;
    logic [1:0]  result_src_s;
    logic [2:0]  alu_ctl_s;
    logic [31:0] imm_s, rd1_s, rd2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;

    // funct3 mapping shared by R and I-ALU; sub only for R-type with funct7[5]
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = sub_en ? 3'b001 : 3'b000;
            3'b010:  ctl = 3'b101;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    assign opcode_s = InstrD[6:0];
    assign funct3_s = InstrD[14:12];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    assign imm_i_s = {{20{InstrD[31]}}, InstrD[31:20]};
    assign imm_s_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b_s = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
    assign imm_j_s = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

    // Main control decode; unknown opcodes fall through as NOP
    always_comb begin
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        jump_s       = 1'b0;
        branch_s     = 1'b0;
        alu_src_s    = 1'b0;
        result_src_s = 2'b00;
        alu_ctl_s    = 3'b000;
        imm_s        = 32'h0000_0000;
        case (opcode_s)
            OP_R: begin
                reg_write_s = 1'b1;
                alu_ctl_s   = alu_decode(funct3_s, InstrD[30]);
            end
            OP_I: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                alu_ctl_s   = alu_decode(funct3_s, 1'b0);
                imm_s       = imm_i_s;
            end
            OP_LW: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = 2'b01;
                imm_s        = imm_i_s;
            end
            OP_SW: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_s       = imm_s_s;
            end
            OP_BEQ: begin
                branch_s  = 1'b1;
                alu_ctl_s = 3'b001;
                imm_s     = imm_b_s;
            end
            OP_JAL: begin
                jump_s       = 1'b1;
                reg_write_s  = 1'b1;
                result_src_s = 2'b10;
                imm_s        = imm_j_s;
            end
            default: begin
                reg_write_s = 1'b0;
            end
        endcase
    end

    // Register file: cleared on reset, written from writeback, x0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (RegWriteW && (RDW != 5'd0)) begin
            regs_r[RDW] <= ResultW;
        end
    end

    // Operand read; x0 is hard-wired to zero
    always_comb begin
        rd1_s = 32'h0000_0000;
        rd2_s = 32'h0000_0000;
        if (Rs1D == 5'd0) begin
            rd1_s = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
        end else if (RegWriteW && (RDW == Rs1D)) begin
            rd1_s = ResultW;
`endif
        end else begin
            rd1_s = regs_r[Rs1D];
        end
        if (Rs2D == 5'd0) begin
            rd2_s = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
        end else if (RegWriteW && (RDW == Rs2D)) begin
            rd2_s = ResultW;
`endif
        end else begin
            rd2_s = regs_r[Rs2D];
        end
    end

    // ID/EX pipeline register; a flush loads an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= 32'h0000_0000;
            RD2E        <= 32'h0000_0000;
            ImmExtE     <= 32'h0000_0000;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            PCE         <= 32'h0000_0000;
            PCPlus4E    <= 32'h0000_0000;
        end else begin
            RegWriteE   <= reg_write_s;
            MemWriteE   <= mem_write_s;
            JumpE       <= jump_s;
            BranchE     <= branch_s;
            ALUSrcE     <= alu_src_s;
            ResultSrcE  <= result_src_s;
            ALUControlE <= alu_ctl_s;
            RD1E        <= rd1_s;
            RD2E        <= rd2_s;
            ImmExtE     <= imm_s;
            RdE         <= InstrD[11:7];
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized instructions
// against a behavioural decode/register-file model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrD = 32'h0, PCD = 32'h0, PCPlus4D = 32'h0, ResultW = 32'h0;
    logic        FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RDW = 5'd0;
    logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

    typedef struct packed {
        logic        rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, pc4;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mregs [32];
    logic [31:0] pc_v = 32'h0000_1000;

    decode_stage dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 3'd1 : 3'd0;
            3'd2:    return 3'd5;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic rw,
                                             input logic [4:0] rdw, input logic [31:0] res);
        if (idx == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (rw && rdw == idx) return res;
`endif
        return mregs[idx];
    endfunction

    // Expected ID/EX contents for one instruction, from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic rw, input logic [4:0] rdw, input logic [31:0] res);
        exp_t e;
        int   imm;
        int   sgn;
        e   = '0;
        imm = 0;
        sgn = ins[31] ? 1 : 0;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        e.rd1 = read_reg(ins[19:15], rw, rdw, res);
        e.rd2 = read_reg(ins[24:20], rw, rdw, res);
        case (ins[6:0])
            7'h33: begin e.rw = 1'b1; e.alu = alu_of(ins[14:12], ins[30]); end
            7'h13: begin
                e.rw = 1'b1; e.as = 1'b1; e.alu = alu_of(ins[14:12], 1'b0);
                imm = int'(ins[30:20]) - sgn * 2048;
            end
            7'h03: begin
                e.rw = 1'b1; e.as = 1'b1; e.rs = 2'd1;
                imm = int'(ins[30:20]) - sgn * 2048;
            end
            7'h23: begin
                e.mw = 1'b1; e.as = 1'b1;
                imm = int'(ins[30:25]) * 32 + int'(ins[11:7]) - sgn * 2048;
            end
            7'h63: begin
                e.b = 1'b1; e.alu = 3'd1;
                imm = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
            end
            7'h6F: begin
                e.j = 1'b1; e.rw = 1'b1; e.rs = 2'd2;
                imm = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                      - sgn * 1048576;
            end
            default: imm = 0;
        endcase
        e.imm = imm;
        return e;
    endfunction

    task automatic chk_all(input exp_t e, input string tag);
        chk({tag, ".RegWriteE"}, RegWriteE, e.rw);
        chk({tag, ".MemWriteE"}, MemWriteE, e.mw);
        chk({tag, ".JumpE"}, JumpE, e.j);
        chk({tag, ".BranchE"}, BranchE, e.b);
        chk({tag, ".ALUSrcE"}, ALUSrcE, e.as);
        chk({tag, ".ResultSrcE"}, ResultSrcE, e.rs);
        chk({tag, ".ALUControlE"}, ALUControlE, e.alu);
        chk({tag, ".RD1E"}, RD1E, e.rd1);
        chk({tag, ".RD2E"}, RD2E, e.rd2);
        chk({tag, ".ImmExtE"}, ImmExtE, e.imm);
        chk({tag, ".RdE"}, RdE, e.rd);
        chk({tag, ".Rs1E"}, Rs1E, e.rs1);
        chk({tag, ".Rs2E"}, Rs2E, e.rs2);
        chk({tag, ".PCE"}, PCE, e.pc);
        chk({tag, ".PCPlus4E"}, PCPlus4E, e.pc4);
    endtask

    // One pipeline cycle: drive, check hazard indices, clock, check ID/EX
    task automatic step(input logic [31:0] ins, input logic fl, input logic rw,
                        input logic [4:0] rdw, input logic [31:0] res, input string tag);
        exp_t e;
        InstrD = ins; PCD = pc_v; PCPlus4D = pc_v + 32'd4;
        FlushE = fl; RegWriteW = rw; RDW = rdw; ResultW = res;
        #1;
        chk({tag, ".Rs1D"}, Rs1D, ins[19:15]);
        chk({tag, ".Rs2D"}, Rs2D, ins[24:20]);
        e = fl ? exp_t'(0) : model(ins, pc_v, rw, rdw, res);
        if (rw && rdw != 5'd0) mregs[rdw] = res;
        @(posedge clk);
        #1;
        chk_all(e, tag);
        pc_v = pc_v + 32'd4;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        logic [6:0]  ops [8];
        logic [4:0]  rdw;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h7F};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        chk_all(exp_t'(0), "reset");
        rst = 1'b1;

        step(32'h0000_007F, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, "illegal_wb5");
        chk("illegal.PCE_eq_PCD", PCE, pc_v - 32'd4);
        step(32'h0002_81B3, 1'b0, 1'b0, 5'd0, 32'h0, "add_x3_x5");
        chk("add.RD1E", RD1E, 32'hDEAD_BEEF);
        chk("add.RdE", RdE, 32'd3);

        step(32'h0000_007F, 1'b0, 1'b1, 5'd5, 32'h0, "clear_x5");
        step(32'h0002_81B3, 1'b0, 1'b1, 5'd5, 32'h1234_5678, "same_cycle");
`ifdef DECODE_WB_BYPASS_EN
        chk("same_cycle.RD1E_bypass", RD1E, 32'h1234_5678);
`else
        chk("same_cycle.RD1E_old", RD1E, 32'h0);
`endif
        step(32'h0002_81B3, 1'b0, 1'b0, 5'd0, 32'h0, "read_after");

        step(32'hFFC0_A103, 1'b0, 1'b0, 5'd0, 32'h0, "lw");
        chk("lw.ImmExtE", ImmExtE, 32'hFFFF_FFFC);
        step(32'hFE00_0CE3, 1'b0, 1'b0, 5'd0, 32'h0, "beq");
        chk("beq.ImmExtE", ImmExtE, 32'hFFFF_FFF8);
        chk("beq.ALUControlE", ALUControlE, 32'd1);

        step(32'h0020_A223, 1'b1, 1'b0, 5'd0, 32'h0, "flush_sw");
        step(32'h0000_007F, 1'b0, 1'b1, 5'd0, 32'h0000_00FF, "wb_x0");
        step(32'h0000_01B3, 1'b0, 1'b0, 5'd0, 32'h0, "read_x0");
        chk("x0.RD1E", RD1E, 32'h0);

        for (int n = 0; n < 200; n++) begin
            r   = $urandom();
            ins = {r[31:7], ops[$urandom_range(0, 7)]};
            rdw = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rdw = ins[19:15];
            step(ins, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rdw, $urandom(), "rand");
        end

        rst = 1'b0;
        #1;
        chk_all(exp_t'(0), "async_rst");
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            ins = {7'd0, 5'(32 - i), 5'(i), 3'd0, 5'd1, 7'h33};
            step(ins, 1'b0, 1'b0, 5'd0, 32'h0, "post_rst_read");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the five-stage RV32I pipeline. It consumes the IF/ID register outputs (instruction, PC, PC+4) and decodes the instruction into control signals. It reads a 32×32 register file, sign-extends the immediate, and registers everything into the ID/EX pipeline register. It also owns the register-file write port driven from writeback, and exports source-register indices to the hazard unit.

## Interface
- No parameters; widths fixed at XLEN=32, 32 architectural registers.
- clk  in  1  pipeline clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- FlushE  in  1  synchronous bubble insert into ID/EX
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- Rs1D, Rs2D  out  5  InstrD[19:15], InstrD[24:20] (combinational, to hazard unit)
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  extended immediate
- RdE, Rs1E, Rs2E  out  5  register indices
- PCE, PCPlus4E  out  32  passed-through PC values

## Operation
- Opcode decode (InstrD[6:0]):
  - 0110011 R: RegWrite=1, ALUSrc=0, ResultSrc=00.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1.
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, ALU=add.
  - 0100011 sw: MemWrite=1, ALUSrc=1, ALU=add.
  - 1100011 beq: Branch=1, ALU=sub.
  - 1101111 jal: Jump=1, RegWrite=1, ResultSrc=10.
- Any other opcode: all control 0 (NOP); data fields still registered.
- ALU control for R/I (funct3, funct7[5]):
  - 000 → add, except R-type with funct7[5]=1 → sub.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - Other funct3 → add.
- Immediates, all sign-extended from InstrD[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - R/other: 0.
- Register file:
  - x0 reads 0 always; writes to x0 are ignored.
  - Write on posedge clk when RegWriteW=1 and RDW≠0.
- ID/EX register:
  - On posedge, captures all decoded values.
  - FlushE=1 loads all E outputs with 0 (bubble = NOP with RegWrite/MemWrite/Jump/Branch=0).

## Timing
- Decode is combinational from InstrD; E outputs are valid 1 cycle after InstrD is presented.
- Reset (rst=0), immediate and asynchronous:
  - All E outputs = 0.
  - All 32 registers = 0.
- Reset release: the first posedge with rst=1 captures normally.
- Reset mid-operation discards the ID/EX contents and the register file contents.
- FlushE takes priority over capture; with FlushE=1, InstrD for that cycle is lost.
- Write and read of the same register in the same cycle: see Configuration.
- Simultaneous RegWriteW with RDW=0: no state change; reads of x0 still return 0.

## Configuration
- DECODE_WB_BYPASS_EN defined: when RegWriteW=1, RDW≠0 and RDW equals Rs1D (or Rs2D), the corresponding RD1/RD2 take ResultW in the same cycle (write-through), so RD1E/RD2E capture the new value at that posedge.
- Undefined: reads return the pre-write array value. The hazard unit must stall one extra cycle for WB→ID dependencies.

## Test plan
- Reset: assert rst=0 mid-stream → all E outputs 0 immediately. After release, reading x1..x31 returns 0.
- Writeback then read: write RDW=5, ResultW=0xDEADBEEF. Next cycle InstrD=add x3,x5,x0 (0x000281B3) → RD1E=0xDEADBEEF, RegWriteE=1, ALUControlE=000, RdE=3.
- Same-cycle WB+read, InstrD=0x000281B3, RDW=5, ResultW=0x12345678, prior x5=0:
  - Macro defined → RD1E=0x12345678.
  - Macro undefined → RD1E=0.
- Immediates:
  - lw x2,-4(x1) (0xFFC0A103) → ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1.
  - beq offset -8 (0xFE000CE3) → ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
- Flush and x0: FlushE=1 with sw in InstrD → MemWriteE=0, all E outputs 0. A write RDW=0, ResultW=0xFF leaves x0 reading 0.
- Illegal opcode 0x0000007F → all E control signals 0, PCE=PCD.
